// File: rtl/game_pkg.sv
// Shared types and constants for the game session sequencer.
`default_nettype none

package game_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_LOAD   = 3'd2,
    S_RUN    = 3'd3,
    S_RECORD = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [1:0] CTRL_UP1   = 2'd0;
  localparam logic [1:0] CTRL_DOWN1 = 2'd1;
  localparam logic [1:0] CTRL_UP2   = 2'd2;
  localparam logic [1:0] CTRL_DOWN2 = 2'd3;

  localparam logic [1:0] WHO_WIN = 2'b10;

  // Increment that sticks at the all-ones value of a width-bit field.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val >= max_val) ? val : val + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/game_round_timer.sv
// RUN-phase cycle counter: clears whenever run is low, flags the last allowed cycle.
`default_nettype none

module game_round_timer #(
  parameter int CYCLES = 512
) (
  input  logic clk,
  input  logic rst_l,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      count <= '0;
    end else if (run) begin
      count <= count + CW'(1);
    end else begin
      count <= '0;
    end
  end

  // Count is 0 on the first RUN cycle, so CYCLES-1 marks the final permitted cycle.
  assign expired = run && (count == CW'(CYCLES - 1));

endmodule

`default_nettype wire

// File: rtl/game_session_ctrl.sv
// Session sequencer driving Game_State through a programmed number of rounds.
// Optional per-round timeout compiled in with `define GAME_TIMEOUT_EN.
`default_nettype none

module game_session_ctrl
  import game_pkg::*;
#(
  parameter int COUNTER_SIZE   = 4,
  parameter int ROUND_W        = 4,
  parameter int TIMEOUT_CYCLES = 512
) (
  input  logic                    clk,
  input  logic                    rst_l,
  input  logic                    start,
  input  logic [1:0]              mode_sel,
  input  logic [COUNTER_SIZE-1:0] seed,
  input  logic [ROUND_W-1:0]      rounds,
  output logic                    gs_reset,
  output logic [1:0]              control,
  output logic [COUNTER_SIZE-1:0] i_value,
  output logic                    INIT,
  input  logic [1:0]              who,
  input  logic                    gameover,
  output logic                    busy,
  output logic                    done,
  output logic [ROUND_W-1:0]      round_cnt,
  output logic [ROUND_W-1:0]      wins,
  output logic [ROUND_W-1:0]      losses,
  output logic [ROUND_W-1:0]      timeouts
);

  state_t state, state_nxt;

  logic [1:0]              mode_q;
  logic [COUNTER_SIZE-1:0] seed_q;
  logic [ROUND_W-1:0]      rounds_q;
  logic [ROUND_W-1:0]      round_nxt;
  logic                    go_q;
  logic                    go_edge;
  logic                    expired;
  logic                    last_round;
  logic                    advance;
  logic                    accept;

  assign accept     = (state == S_IDLE) && start;
  assign go_edge    = gameover & ~go_q;
  assign round_nxt  = round_cnt + ROUND_W'(1);
  assign last_round = (round_nxt == rounds_q);
  assign advance    = (state == S_RECORD) || ((state == S_RUN) && expired && !go_edge);

`ifdef GAME_TIMEOUT_EN
  game_round_timer #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst_l   (rst_l),
    .run     (state == S_RUN),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      timeouts <= '0;
    end else if (accept) begin
      timeouts <= '0;
    end else if ((state == S_RUN) && expired && !go_edge) begin
      timeouts <= ROUND_W'(sat_inc(32'(timeouts), ROUND_W));
    end
  end
`else
  assign expired  = 1'b0;
  assign timeouts = '0;
`endif

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (rounds == '0) ? S_DONE : S_CLEAR;
        end
      end
      S_CLEAR:  state_nxt = S_LOAD;
      S_LOAD:   state_nxt = S_RUN;
      S_RUN: begin
        if (go_edge) begin
          state_nxt = S_RECORD;
        end else if (expired) begin
          state_nxt = last_round ? S_DONE : S_CLEAR;
        end
      end
      S_RECORD: state_nxt = last_round ? S_DONE : S_CLEAR;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    gs_reset = (state == S_IDLE) || (state == S_CLEAR) || (state == S_DONE);
    INIT     = (state == S_LOAD);
    done     = (state == S_DONE);
    busy     = (state != S_IDLE);
  end

  // Edge-detect history is wiped while the core sits in reset so a stale high never counts.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      go_q <= 1'b0;
    end else if (state == S_CLEAR) begin
      go_q <= 1'b0;
    end else begin
      go_q <= gameover;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      mode_q    <= CTRL_UP1;
      seed_q    <= '0;
      rounds_q  <= '0;
      control   <= CTRL_UP1;
      i_value   <= '0;
      round_cnt <= '0;
      wins      <= '0;
      losses    <= '0;
    end else begin
      if (accept) begin
        mode_q    <= mode_sel;
        seed_q    <= seed;
        rounds_q  <= rounds;
        round_cnt <= '0;
        wins      <= '0;
        losses    <= '0;
      end
      // Load values are registered on the CLEAR->LOAD edge and simply held through RUN.
      if (state == S_CLEAR) begin
        control <= mode_q;
        i_value <= seed_q + COUNTER_SIZE'(round_cnt);
      end
      if (advance) begin
        round_cnt <= round_nxt;
      end
      if (state == S_RECORD) begin
        if (who == WHO_WIN) begin
          wins <= ROUND_W'(sat_inc(32'(wins), ROUND_W));
        end else begin
          losses <= ROUND_W'(sat_inc(32'(losses), ROUND_W));
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_game_session_ctrl.sv
// Scoreboard bench for game_session_ctrl; the game core is emulated by driving gameover/who.
`default_nettype none

module tb_game_session_ctrl;

  logic       clk = 1'b0;
  logic       rst_l;
  logic       start;
  logic [1:0] mode_sel;
  logic [3:0] seed;
  logic [3:0] rounds;
  logic       gs_reset;
  logic [1:0] control;
  logic [3:0] i_value;
  logic       INIT;
  logic [1:0] who;
  logic       gameover;
  logic       busy;
  logic       done;
  logic [3:0] round_cnt;
  logic [3:0] wins;
  logic [3:0] losses;
  logic [3:0] timeouts;

  int n_cmp = 0;
  int n_bad = 0;

  logic [5:0]  load_q[$];
  logic [15:0] done_q[$];

  always #5 clk = ~clk;

  game_session_ctrl #(
    .COUNTER_SIZE   (4),
    .ROUND_W        (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk       (clk),
    .rst_l     (rst_l),
    .start     (start),
    .mode_sel  (mode_sel),
    .seed      (seed),
    .rounds    (rounds),
    .gs_reset  (gs_reset),
    .control   (control),
    .i_value   (i_value),
    .INIT      (INIT),
    .who       (who),
    .gameover  (gameover),
    .busy      (busy),
    .done      (done),
    .round_cnt (round_cnt),
    .wins      (wins),
    .losses    (losses),
    .timeouts  (timeouts)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every INIT pulse and every done pulse consumes one expected entry.
  always @(negedge clk) begin
    if (INIT === 1'b1) begin
      if (load_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL load_unexpected: got INIT with control=%0d i_value=%0d, expected none", control, i_value);
      end else begin
        check("load", 32'({control, i_value}), 32'(load_q.pop_front()));
      end
    end
    if (done === 1'b1) begin
      if (done_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL done_unexpected: got done with round_cnt=%0d, expected none", round_cnt);
      end else begin
        check("done_tally", 32'({round_cnt, wins, losses, timeouts}), 32'(done_q.pop_front()));
      end
    end
  end

  task automatic run_session(input logic [1:0] m, input logic [3:0] s, input logic [3:0] n,
                             input logic [15:0] mask, input int d);
    logic [3:0] w;
    int nn;
    nn = int'(n);
    w  = 4'd0;
    for (int r = 0; r < nn; r++) begin
      load_q.push_back({m, 4'(s + 4'(r))});
      w = w + 4'(mask[r]);
    end
    done_q.push_back({n, w, n - w, 4'd0});
    start = 1'b1; mode_sel = m; seed = s; rounds = n;
    @(negedge clk);
    start = 1'b0;
    check("c1_clear", 32'({busy, gs_reset, INIT}), 32'(3'b110));
    @(negedge clk);
    check("c2_load", 32'({gs_reset, INIT}), 32'(2'b01));
    for (int r = 0; r < nn; r++) begin
      repeat (d) @(negedge clk);
      check("run_ctrl", 32'(control), 32'(m));
      gameover = 1'b1;
      who = mask[r] ? 2'b10 : ((r % 2 != 0) ? 2'b11 : 2'b01);
      @(negedge clk);
      check("record", 32'({gs_reset, INIT, done}), 32'(3'b000));
      gameover = 1'b0;
      @(negedge clk);
      if (r == nn - 1) begin
        check("done_cycle", 32'({done, gs_reset}), 32'(2'b11));
      end else begin
        check("reclear", 32'({done, gs_reset, INIT}), 32'(3'b010));
        @(negedge clk);
        check("reload", 32'({gs_reset, INIT}), 32'(2'b01));
      end
    end
    @(negedge clk);
    check("idle_after", 32'({busy, done, gs_reset}), 32'(3'b001));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end of run");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_l = 1'b0; start = 1'b0; mode_sel = 2'd0; seed = 4'd0; rounds = 4'd0;
    who = 2'b00; gameover = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ctrl_flags", 32'({gs_reset, INIT, busy, done}), 32'(4'b1000));
    check("rst_load_vals", 32'({control, i_value}), 32'(6'd0));
    check("rst_tallies", 32'({round_cnt, wins, losses, timeouts}), 32'(16'd0));
    rst_l = 1'b1;
    @(negedge clk);

    // Up by 1, one round, win.
    run_session(2'd0, 4'd0, 4'd1, 16'h0001, 1);
    // Down by 2, four rounds, seed wraps: 15, 0, 1, 2.
    run_session(2'd3, 4'd15, 4'd4, 16'h0005, 3);

    // Zero rounds: immediate done, core never released, tallies cleared.
    done_q.push_back(16'h0000);
    start = 1'b1; mode_sel = 2'd1; seed = 4'd9; rounds = 4'd0;
    @(negedge clk);
    start = 1'b0;
    check("zero_done", 32'({done, gs_reset, INIT}), 32'(3'b110));
    repeat (3) begin
      @(negedge clk);
      check("zero_idle", 32'({INIT, gs_reset, busy}), 32'(3'b010));
    end

    run_session(2'd2, 4'd7, 4'd3, 16'h0000, 2);

    // Start while busy, then asynchronous reset mid-round.
    load_q.push_back({2'd0, 4'd5});
    load_q.push_back({2'd0, 4'd6});
    start = 1'b1; mode_sel = 2'd0; seed = 4'd5; rounds = 4'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    gameover = 1'b1; who = 2'b10;
    @(negedge clk);
    gameover = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; mode_sel = 2'd3; seed = 4'd1; rounds = 4'd1;
    @(negedge clk);
    start = 1'b0;
    check("busy_start_ctrl", 32'({control, busy, INIT}), 32'({2'd0, 1'b1, 1'b0}));
    @(negedge clk);
    check("busy_start_hold", 32'({control, i_value, round_cnt, wins}), 32'({2'd0, 4'd6, 4'd1, 4'd1}));
    #2 rst_l = 1'b0;
    #1;
    check("async_rst_flags", 32'({gs_reset, INIT, busy, done}), 32'(4'b1000));
    check("async_rst_vals", 32'({control, i_value, round_cnt, wins, losses}), 32'(18'd0));
    @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);
    check("post_rst_idle", 32'({busy, gs_reset}), 32'(2'b01));

    run_session(2'd1, 4'd4, 4'd2, 16'h0002, 1);

`ifdef GAME_TIMEOUT_EN
    load_q.push_back({2'd1, 4'd3});
    load_q.push_back({2'd1, 4'd4});
    done_q.push_back({4'd2, 4'd0, 4'd0, 4'd2});
    start = 1'b1; mode_sel = 2'd1; seed = 4'd3; rounds = 4'd2;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      repeat (8) @(negedge clk);
      check("to_still_run", 32'({gs_reset, INIT, done}), 32'(3'b000));
      @(negedge clk);
      if (r == 0) begin
        check("to_clear", 32'({gs_reset, INIT, done}), 32'(3'b100));
        @(negedge clk);
        check("to_reload", 32'(INIT), 32'(1'b1));
      end else begin
        check("to_done", 32'({done, gs_reset}), 32'(2'b11));
      end
    end
    @(negedge clk);
`endif

    check("load_q_drained", 32'(load_q.size()), 32'd0);
    check("done_q_drained", 32'(done_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
